mem_req_abuf: RTL and testbench

Parametrised arrival buffer between the ring's memory-bound flit port and the local memory controller. Queues up to DEPTH incoming request flits, presents the oldest one to memory with a single-cycle issue strobe, and retires it when memory reports completion. Generalises the single-entry memory-side arrival register to multi-entry storage with back-pressure and an explicit issue/access state machine.

---
 rtl/mem_req_pkg.sv | 14 +
 rtl/mem_req_abuf_ram.sv | 26 ++
 rtl/mem_req_abuf.sv | 119 +++++++++++
 tb/tb_mem_req_abuf.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared definitions for the memory-side request arrival buffer:
// default geometry and the issue/access FSM state encoding.
package mem_req_pkg;

    localparam int AREG_FLIT_W_DEF = 48;
    localparam int AREG_DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        ACCESS = 2'd2
    } areg_state_t;

endpackage

// File: rtl/mem_req_abuf_ram.sv
// Flit storage for the arrival buffer: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module mem_req_abuf_ram #(
    parameter int FLIT_W = 48,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [FLIT_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [FLIT_W-1:0] rdata
);

    logic [FLIT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_req_abuf.sv
// Multi-entry arrival buffer between the ring's memory-bound port and the
// memory controller. Optional sticky overflow flag: define AREG_OVF_CHECK_EN.
module mem_req_abuf
    import mem_req_pkg::*;
#(
    parameter int FLIT_W = AREG_FLIT_W_DEF,
    parameter int DEPTH  = AREG_DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] i_flits_m,
    input  logic              v_i_flits_m,
    output logic              i_m_ready,
    input  logic              mem_done_access,
    output logic [FLIT_W-1:0] areg_flits,
    output logic              v_areg_flits,
    output logic              areg_busy,
    output logic [CNT_W-1:0]  areg_count,
    output logic              areg_ovf
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    areg_state_t      state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic [FLIT_W-1:0] rd_data;

    assign i_m_ready  = (count != FULL_CNT);
    assign push       = v_i_flits_m && i_m_ready;
    assign pop        = (state == ACCESS) && mem_done_access;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    mem_req_abuf_ram #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (i_flits_m),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Issue decisions use the post-pop count so a push landing in the
    // retire cycle keeps the pipeline going without an IDLE bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (mem_done_access) begin
                        state <= (count_next != '0) ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign v_areg_flits = (state == ISSUE);
    assign areg_busy    = (state != IDLE);
    assign areg_count   = count;
    // Storage is unreset, so hide it while empty to give a clean zero.
    assign areg_flits   = (count != '0) ? rd_data : '0;

`ifdef AREG_OVF_CHECK_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (v_i_flits_m && (count == FULL_CNT)) begin
            ovf_q <= 1'b1;
        end
    end

    assign areg_ovf = ovf_q;
`else
    assign areg_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_abuf.sv
// Directed bench for mem_req_abuf; issued flits are checked against a
// scoreboard queue filled as flits are offered to the buffer.
module tb_mem_req_abuf;

    localparam int FLIT_W = 48;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic [FLIT_W-1:0] i_flits_m;
    logic              v_i_flits_m;
    logic              i_m_ready;
    logic              mem_done_access;
    logic [FLIT_W-1:0] areg_flits;
    logic              v_areg_flits;
    logic              areg_busy;
    logic [CNT_W-1:0]  areg_count;
    logic              areg_ovf;

    int                compared;
    int                mismatched;
    int                model_count;
    logic [FLIT_W-1:0] exp_q[$];
    logic              exp_ovf;

    mem_req_abuf #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_flits_m       (i_flits_m),
        .v_i_flits_m     (v_i_flits_m),
        .i_m_ready       (i_m_ready),
        .mem_done_access (mem_done_access),
        .areg_flits      (areg_flits),
        .v_areg_flits    (v_areg_flits),
        .areg_busy       (areg_busy),
        .areg_count      (areg_count),
        .areg_ovf        (areg_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one edge, then act as the scoreboard consumer for any issue strobe.
    task automatic step();
        logic [FLIT_W-1:0] exp_flit;
        @(posedge clk);
        #1;
        if (v_areg_flits === 1'b1) begin
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("[TB] FAIL unexpected_strobe: observed flit %0h expected no issue", areg_flits);
            end
            if (exp_q.size() != 0) begin
                exp_flit = exp_q.pop_front();
                checkOutput("issue_flit", {16'h0, areg_flits}, {16'h0, exp_flit});
            end
        end
    endtask

    task automatic applyStimulus(input logic push_v, input logic [FLIT_W-1:0] data, input logic done);
        if (push_v && model_count < DEPTH) begin
            exp_q.push_back(data);
            model_count++;
        end
        v_i_flits_m     = push_v;
        i_flits_m       = data;
        mem_done_access = done;
        step();
        v_i_flits_m     = 1'b0;
        mem_done_access = 1'b0;
    endtask

    task automatic retireHead();
        logic found;
        found = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (areg_busy === 1'b1 && v_areg_flits === 1'b0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        compared++;
        assert (found) else begin
            mismatched++;
            $error("[TB] FAIL access_timeout: observed no ACCESS state expected ACCESS within 16 cycles");
        end
        if (found) begin
            applyStimulus(1'b0, '0, 1'b1);
            model_count--;
            checkOutput("count_after_retire", 64'(areg_count), 64'(model_count));
        end
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        model_count     = 0;
        rst_n           = 1'b0;
        i_flits_m       = '0;
        v_i_flits_m     = 1'b0;
        mem_done_access = 1'b0;
`ifdef AREG_OVF_CHECK_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif

        // Reset values, then quiet idle.
        #12;
        checkOutput("rst_ready", 64'(i_m_ready), 64'd1);
        checkOutput("rst_count", 64'(areg_count), 64'd0);
        checkOutput("rst_strobe", 64'(v_areg_flits), 64'd0);
        checkOutput("rst_busy", 64'(areg_busy), 64'd0);
        checkOutput("rst_ovf", 64'(areg_ovf), 64'd0);
        checkOutput("rst_flits", {16'h0, areg_flits}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput("idle_strobe", 64'(v_areg_flits), 64'd0);
            checkOutput("idle_count", 64'(areg_count), 64'd0);
            checkOutput("idle_ready", 64'(i_m_ready), 64'd1);
        end

        // Single flit into empty buffer: strobe one edge after the push.
        applyStimulus(1'b1, 48'h0000_1234_5678, 1'b0);
        checkOutput("single_count", 64'(areg_count), 64'd1);
        checkOutput("single_no_early_strobe", 64'(v_areg_flits), 64'd0);
        step();
        checkOutput("single_strobe", 64'(v_areg_flits), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("single_strobe_low", 64'(v_areg_flits), 64'd0);
            checkOutput("single_busy", 64'(areg_busy), 64'd1);
            checkOutput("single_stable", {16'h0, areg_flits}, 64'h0000_1234_5678);
        end
        retireHead();
        checkOutput("single_idle", 64'(areg_busy), 64'd0);

        // Fill to DEPTH, offer one more, then drain in order.
        applyStimulus(1'b1, 48'hAAAA_0000_0001, 1'b0);
        applyStimulus(1'b1, 48'hBBBB_0000_0002, 1'b0);
        applyStimulus(1'b1, 48'hCCCC_0000_0003, 1'b0);
        applyStimulus(1'b1, 48'hDDDD_0000_0004, 1'b0);
        checkOutput("full_count", 64'(areg_count), 64'd4);
        checkOutput("full_ready", 64'(i_m_ready), 64'd0);
        checkOutput("full_ovf_before", 64'(areg_ovf), 64'd0);
        applyStimulus(1'b1, 48'hEEEE_0000_0005, 1'b0);
        checkOutput("drop_count", 64'(areg_count), 64'd4);
        checkOutput("drop_ovf", 64'(areg_ovf), 64'(exp_ovf));
        for (int i = 0; i < 4; i++) begin
            retireHead();
        end
        checkOutput("drain_ready", 64'(i_m_ready), 64'd1);

        // Push in the retire cycle with two entries held.
        applyStimulus(1'b1, 48'h1111_2222_0001, 1'b0);
        applyStimulus(1'b1, 48'h1111_2222_0002, 1'b0);
        step();
        checkOutput("overlap_pre_count", 64'(areg_count), 64'd2);
        applyStimulus(1'b1, 48'h1111_2222_0003, 1'b1);
        model_count--;
        checkOutput("overlap_count", 64'(areg_count), 64'd2);
        checkOutput("overlap_next_issue", 64'(v_areg_flits), 64'd1);
        retireHead();
        retireHead();

        // Completion pulses outside ACCESS are ignored.
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("done_idle_count", 64'(areg_count), 64'd0);
        checkOutput("done_idle_busy", 64'(areg_busy), 64'd0);
        applyStimulus(1'b1, 48'h5555_6666_7777, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("done_idle1_count", 64'(areg_count), 64'd1);
        checkOutput("done_idle1_issue", 64'(v_areg_flits), 64'd1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("done_issue_count", 64'(areg_count), 64'd1);
        checkOutput("done_issue_flits", {16'h0, areg_flits}, 64'h5555_6666_7777);
        checkOutput("done_issue_busy", 64'(areg_busy), 64'd1);
        retireHead();

        // Asynchronous reset in ACCESS with three entries held.
        applyStimulus(1'b1, 48'h0BAD_0000_0001, 1'b0);
        applyStimulus(1'b1, 48'h0BAD_0000_0002, 1'b0);
        applyStimulus(1'b1, 48'h0BAD_0000_0003, 1'b0);
        checkOutput("pre_reset_count", 64'(areg_count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_count", 64'(areg_count), 64'd0);
        checkOutput("async_rst_busy", 64'(areg_busy), 64'd0);
        checkOutput("async_rst_strobe", 64'(v_areg_flits), 64'd0);
        checkOutput("async_rst_ready", 64'(i_m_ready), 64'd1);
        checkOutput("async_rst_flits", {16'h0, areg_flits}, 64'd0);
        checkOutput("async_rst_ovf", 64'(areg_ovf), 64'd0);
        exp_q.delete();
        model_count = 0;
        step();
        checkOutput("held_rst_strobe", 64'(v_areg_flits), 64'd0);
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_strobe", 64'(v_areg_flits), 64'd0);

        // Eight push/retire rounds walk the pointers through two wraps.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, {16'hC0DE, 16'(i), 16'($urandom_range(0, 16'hFFFF))}, 1'b0);
            retireHead();
        end
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
